mdio_master: RTL

- Clause-22 MDIO management master that sits directly downstream of driver_operation.
- driver_operation issues operation/address/value requests for PHY register access. This block serialises each request onto eth_mdc/eth_mdio and returns the read data.
- The tristate eth_mdio pad is assembled one level up from mdio_o/mdio_oe/mdio_i.

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_clk_div.sv | 44 ++++
 rtl/mdio_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause-22 MDIO management master.
package mdio_pkg;

    typedef enum logic {
        MDIO_WRITE = 1'b0,
        MDIO_READ  = 1'b1
    } mdio_op_t;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int unsigned MDIO_HDR_BITS  = 32;
    localparam int unsigned MDIO_BIT_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } mdio_state_t;

    // Non-preamble part of a frame, bit 31 goes out first.
    function automatic logic [31:0] mdio_header(input mdio_op_t op, input logic [4:0] phy,
                                                input logic [4:0] reg_a, input logic [15:0] data);
        logic [1:0] op_bits;
        logic [1:0] ta_bits;
        op_bits = (op == MDIO_READ) ? MDIO_OP_RD : MDIO_OP_WR;
        ta_bits = (op == MDIO_READ) ? 2'b11 : MDIO_TA_WR;
        return {MDIO_ST, op_bits, phy, reg_a, ta_bits, data};
    endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// MDC half-period divider: phase is the MDC level, ticks mark the first high
// cycle (rise_tick) and the last high cycle (fall_tick) of each bit.
module mdio_clk_div #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic phase,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            phase     <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else if (!en) begin
            cnt       <= '0;
            phase     <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            // Ticks are registered one cycle ahead so they line up with phase.
            rise_tick <= !phase && (cnt == CNT_LAST);
            fall_tick <= phase && (cnt == CNT_PRE);
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one read/write request per frame onto
// MDC/MDIO and returns the read data and a no-responder flag.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic        operation,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_value,
    output logic        done_port,
    output logic        busy,
    output logic [15:0] rd_value,
    output logic        rd_error,
    output logic        eth_mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int unsigned NB = PREAMBLE_LEN + MDIO_HDR_BITS;
    localparam int unsigned BW = MDIO_BIT_CNT_W;
    localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);
    localparam logic [BW-1:0] TA_BIT   = BW'(PREAMBLE_LEN + 14);
    localparam logic [BW-1:0] ERR_BIT  = BW'(PREAMBLE_LEN + 15);
    localparam logic [BW-1:0] DATA_BIT = BW'(PREAMBLE_LEN + 16);

    mdio_state_t   state;
    logic [31:0]   hdr;
    logic          op_rd;
    logic [BW-1:0] bit_cnt;
    logic [15:0]   cap;
    logic          err_cap;
    logic [1:0]    mdio_sync;
    logic          phase;
    logic          rise_tick;
    logic          fall_tick;
    logic [BW-1:0] nxt_bit;
    logic          nxt_oe;

    function automatic logic frame_bit(input logic [31:0] word, input logic [BW-1:0] idx);
        logic [BW-1:0] off;
        if (int'(idx) < int'(PREAMBLE_LEN)) return 1'b1;
        off = idx - BW'(PREAMBLE_LEN);
        return word[5'(BW'(31) - off)];
    endfunction

    mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clock     (clock),
        .reset     (reset),
        .en        (state == ST_SHIFT),
        .phase     (phase),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign eth_mdc = phase;
    assign nxt_bit = bit_cnt + BW'(1);
    // Reads release the line from the first turnaround bit onwards.
    assign nxt_oe  = !op_rd || (nxt_bit < TA_BIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdio_sync <= 2'b11;
        end else begin
            mdio_sync <= {mdio_sync[0], mdio_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            hdr       <= '0;
            op_rd     <= 1'b0;
            bit_cnt   <= '0;
            cap       <= '0;
            err_cap   <= 1'b0;
            done_port <= 1'b0;
            busy      <= 1'b0;
            rd_value  <= '0;
            rd_error  <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
        end else begin
            done_port <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mdio_o  <= 1'b1;
                    mdio_oe <= 1'b0;
                    if (start_port) begin
                        hdr     <= mdio_header(mdio_op_t'(operation), phy_addr, reg_addr, wr_value);
                        op_rd   <= (mdio_op_t'(operation) == MDIO_READ);
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        mdio_o  <= frame_bit(mdio_header(mdio_op_t'(operation), phy_addr,
                                                         reg_addr, wr_value), '0);
                        mdio_oe <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rise_tick && op_rd) begin
                        if (bit_cnt == ERR_BIT) err_cap <= mdio_sync[1];
                        if (bit_cnt >= DATA_BIT) cap <= {cap[14:0], mdio_sync[1]};
                    end
                    if (fall_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state     <= ST_DONE;
                            done_port <= 1'b1;
                            mdio_o    <= 1'b1;
                            mdio_oe   <= 1'b0;
                            if (op_rd) begin
                                rd_value <= cap;
                                rd_error <= err_cap;
                            end else begin
                                rd_error <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= nxt_bit;
                            mdio_oe <= nxt_oe;
                            mdio_o  <= nxt_oe ? frame_bit(hdr, nxt_bit) : 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
